// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the transmitter FSM state
// encoding, default oversample factors, frame-length constants and the
// parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default oversample factors (apb_bsel = 0 selects HI, 1 selects LO).
    localparam int OVS_HI_DEF     = 16;
    localparam int OVS_LO_DEF     = 8;

    // Frame geometry, in bit periods.
    localparam int DATA_BITS      = 8;
    localparam int FRAME_BITS     = 10;  // start + 8 data + stop
    localparam int FRAME_BITS_PAR = 11;  // start + 8 data + parity + stop

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// -----------------------------------------------------------------------------
// uart_tx_baud
// Bit-period timer for the transmitter. A prescaler counts 0..apb_brg and
// advances an oversample counter that counts 0..OVS-1. bit_end marks the last
// pclk of a bit period, i.e. both counters at terminal count, so one bit
// lasts OVS * (apb_brg + 1) cycles.
//
// Ports:
//   pclk, prst_n  clock, async active-low reset
//   clr           synchronous clear of both counters (frame load / idle)
//   apb_brg       baud divisor (prescaler terminal count)
//   ovs_sel       0: OVS_HI, 1: OVS_LO
//   bit_end       last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_tx_baud #(
    parameter int OVS_HI = 16,
    parameter int OVS_LO = 8
) (
    input  logic       pclk,
    input  logic       prst_n,
    input  logic       clr,
    input  logic [7:0] apb_brg,
    input  logic       ovs_sel,
    output logic       bit_end
);

    localparam int OVS_MAX = (OVS_HI > OVS_LO) ? OVS_HI : OVS_LO;
    localparam int OW      = $clog2(OVS_MAX);

    logic [7:0]    pre_cnt;
    logic [OW-1:0] ovs_cnt;
    logic [OW-1:0] ovs_top;
    logic          pre_tc;
    logic          ovs_tc;

    assign ovs_top = ovs_sel ? OW'(OVS_LO - 1) : OW'(OVS_HI - 1);
    assign pre_tc  = (pre_cnt == apb_brg);
    assign ovs_tc  = (ovs_cnt == ovs_top);
    assign bit_end = pre_tc & ovs_tc;

    // Both counters wrap to zero on bit_end, so consecutive bits need no
    // explicit clear; clr is only used to align the first bit of a frame.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pre_cnt <= '0;
            ovs_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
            ovs_cnt <= '0;
        end else if (pre_tc) begin
            pre_cnt <= '0;
            ovs_cnt <= ovs_tc ? '0 : ovs_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART serial transmitter. Pops one byte at a time from the APB-side TX FIFO
// and shifts it out on uart_txd as: start (0), 8 data bits LSB first,
// optional even parity (apb_d9 = 1), one stop bit (1). Back-to-back frames
// are sent with no idle time between the stop bit and the next start bit.
//
// Ports:
//   pclk, prst_n  clock, async active-low reset
//   apb_en        UART enable; low aborts any frame in progress
//   apb_tx_en     FIFO not empty and UART enabled
//   apb_data      FIFO head entry
//   apb_brg       baud divisor, static while apb_en = 1
//   apb_bsel      oversample select (0: OVS_HI, 1: OVS_LO), sampled at load
//   apb_d9        append even-parity bit, sampled at load
//   tx_txff_rd    one-cycle FIFO pop strobe (combinational)
//   tx_busy       frame in progress (registered)
//   uart_txd      serial output, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVS_HI = OVS_HI_DEF,
    parameter int OVS_LO = OVS_LO_DEF
) (
    input  logic       pclk,
    input  logic       prst_n,
    input  logic       apb_en,
    input  logic       apb_tx_en,
    input  logic [7:0] apb_data,
    input  logic [7:0] apb_brg,
    input  logic       apb_bsel,
    input  logic       apb_d9,
    output logic       tx_txff_rd,
    output logic       tx_busy,
    output logic       uart_txd
);

    tx_state_t state;
    tx_state_t state_nxt;

    logic       load;      // pop + capture this cycle
    logic       cnt_clr;   // hold the bit timer at zero
    logic       bit_end;

    logic [7:0] shreg;     // remaining data bits, LSB goes out next
    logic [2:0] bit_idx;   // data bit currently on the line
    logic       par_q;     // parity of the captured byte
    logic       d9_q;      // frame format latched at load
    logic       sel_q;     // oversample select latched at load
    logic       txd_q;
    logic       busy_q;

    // -------------------------------------------------------------------------
    // Bit timer
    // -------------------------------------------------------------------------
    uart_tx_baud #(
        .OVS_HI (OVS_HI),
        .OVS_LO (OVS_LO)
    ) u_baud (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .clr     (cnt_clr),
        .apb_brg (apb_brg),
        .ovs_sel (sel_q),
        .bit_end (bit_end)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (!apb_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (apb_tx_en) state_nxt = ST_START;
                ST_START:  if (bit_end)   state_nxt = ST_DATA;
                ST_DATA:   if (bit_end && bit_idx == 3'(DATA_BITS - 1))
                               state_nxt = d9_q ? ST_PARITY : ST_STOP;
                ST_PARITY: if (bit_end)   state_nxt = ST_STOP;
                ST_STOP:   if (bit_end)   state_nxt = apb_tx_en ? ST_START : ST_IDLE;
                default:                  state_nxt = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // The pop is Mealy so the next start bit can begin on the very edge that
    // ends the previous stop bit. Gating with apb_tx_en keeps the FIFO from
    // being read while empty.
    // -------------------------------------------------------------------------
    always_comb begin
        load    = apb_tx_en & apb_en &
                  ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
        cnt_clr = load | ~apb_en | (state == ST_IDLE);
    end

    assign tx_txff_rd = load;

    // -------------------------------------------------------------------------
    // Datapath: shift register, parity, serial line
    // uart_txd only moves on a load edge or a bit_end edge, so each level on
    // the line lasts exactly one bit period.
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
            par_q   <= 1'b0;
            d9_q    <= 1'b0;
            sel_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt != ST_IDLE);
            if (!apb_en) begin
                // Abort: the byte in flight is dropped, line returns to idle.
                txd_q   <= 1'b1;
                bit_idx <= '0;
            end else if (load) begin
                shreg   <= apb_data;
                par_q   <= even_parity(apb_data);
                d9_q    <= apb_d9;
                sel_q   <= apb_bsel;
                bit_idx <= '0;
                txd_q   <= 1'b0;          // start bit
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        txd_q   <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            txd_q <= d9_q ? par_q : 1'b1;
                        end else begin
                            txd_q   <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: txd_q <= 1'b1;  // parity -> stop, stop -> idle
                endcase
            end
        end
    end

    assign tx_busy  = busy_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       pclk = 1'b0;
    logic       prst_n;
    logic       apb_en;
    logic       apb_tx_en;
    logic [7:0] apb_data;
    logic [7:0] apb_brg;
    logic       apb_bsel;
    logic       apb_d9;
    logic       tx_txff_rd;
    logic       tx_busy;
    logic       uart_txd;

    always #5 pclk = ~pclk;

    uart_tx dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .apb_en     (apb_en),
        .apb_tx_en  (apb_tx_en),
        .apb_data   (apb_data),
        .apb_brg    (apb_brg),
        .apb_bsel   (apb_bsel),
        .apb_d9     (apb_d9),
        .tx_txff_rd (tx_txff_rd),
        .tx_busy    (tx_busy),
        .uart_txd   (uart_txd)
    );

    // APB-side FIFO: pushed by stimulus, popped when the model says a pop occurs.
    logic [7:0] fifo [0:15];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    assign apb_tx_en = apb_en && (rd_ptr != wr_ptr);
    assign apb_data  = fifo[rd_ptr[3:0]];

    // Frame-level model: the whole frame as a bit array, position = cycle / Tbit.
    logic        m_active = 1'b0;
    int          m_cyc    = 0;
    int          m_nbits  = 10;
    int          m_tbit   = 8;
    logic [10:0] m_frame  = '1;

    function automatic logic m_pop();
        return apb_en && apb_tx_en && (!m_active || m_cyc == m_nbits * m_tbit - 1);
    endfunction

    function automatic logic m_txd();
        return m_active ? m_frame[m_cyc / m_tbit] : 1'b1;
    endfunction

    always @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            m_active <= 1'b0;
            m_cyc    <= 0;
        end else if (!apb_en) begin
            m_active <= 1'b0;
        end else if (m_pop()) begin
            m_active <= 1'b1;
            m_cyc    <= 0;
            m_nbits  <= apb_d9 ? 11 : 10;
            m_tbit   <= (apb_bsel ? 8 : 16) * (int'(apb_brg) + 1);
            m_frame  <= apb_d9 ? {1'b1, ^apb_data, apb_data, 1'b0}
                               : {2'b11, apb_data, 1'b0};
            rd_ptr   <= rd_ptr + 1;
        end else if (m_active) begin
            if (m_cyc == m_nbits * m_tbit - 1) m_active <= 1'b0;
            else                               m_cyc    <= m_cyc + 1;
        end
    end

    int checks = 0;
    int fails  = 0;
    int cyc_no = 0, pop_cnt = 0, busy_cnt = 0, one_cnt = 0;
    int pop_time [0:63];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Push one byte and sample the line at the middle of each bit.
    task automatic send_capture(input logic [7:0] b, input int nb, input int tb,
                                output logic [10:0] bits);
        bits = '0;
        push(b);
        step(1);
        step(tb / 2);
        for (int i = 0; i < nb; i++) begin
            bits[i] = uart_txd;
            step(tb);
        end
    endtask

    logic [10:0] bits;
    int b0, p0, o0;

    initial begin
        prst_n   = 1'b0;
        apb_en   = 1'b0;
        apb_brg  = 8'd0;
        apb_bsel = 1'b1;
        apb_d9   = 1'b0;

        fork
            forever begin
                @(negedge pclk);
                cyc_no++;
                chk("txd",  32'(uart_txd),   32'(m_txd()));
                chk("busy", 32'(tx_busy),    32'(m_active));
                chk("pop",  32'(tx_txff_rd), 32'(m_pop()));
                if (tx_txff_rd) begin
                    pop_time[pop_cnt % 64] = cyc_no;
                    pop_cnt++;
                end
                if (tx_busy)  busy_cnt++;
                if (uart_txd) one_cnt++;
            end
        join_none

        // Reset values
        step(3);
        chk("rst_txd",  32'(uart_txd),   32'd1);
        chk("rst_busy", 32'(tx_busy),    32'd0);
        chk("rst_pop",  32'(tx_txff_rd), 32'd0);
        prst_n = 1'b1;
        step(2);
        apb_en = 1'b1;
        step(1);

        // Single byte 0xA5, Tbit = 8
        b0 = busy_cnt; p0 = pop_cnt;
        send_capture(8'hA5, 10, 8, bits);
        chk("a5_bits", 32'(bits[9:0]), 32'h34A);
        chk("a5_busy", 32'(busy_cnt - b0), 32'd80);
        chk("a5_pops", 32'(pop_cnt - p0), 32'd1);

        // Parity frame 0x07
        apb_d9 = 1'b1;
        b0 = busy_cnt; p0 = pop_cnt;
        send_capture(8'h07, 11, 8, bits);
        chk("p07_bits",   32'(bits), 32'h60E);
        chk("p07_parity", 32'(bits[9]), 32'd1);
        chk("p07_busy",   32'(busy_cnt - b0), 32'd88);
        chk("p07_pops",   32'(pop_cnt - p0), 32'd1);
        apb_d9 = 1'b0;

        // Three queued bytes, Tbit = 48
        apb_en = 1'b0; apb_brg = 8'd2; apb_bsel = 1'b0;
        step(1);
        apb_en = 1'b1;
        b0 = busy_cnt; p0 = pop_cnt;
        push(8'h55); push(8'hC3); push(8'h0F);
        step(1500);
        chk("b2b_pops",  32'(pop_cnt - p0), 32'd3);
        chk("b2b_gap1",  32'(pop_time[p0 + 1] - pop_time[p0]), 32'd480);
        chk("b2b_gap2",  32'(pop_time[p0 + 2] - pop_time[p0 + 1]), 32'd480);
        chk("b2b_busy",  32'(busy_cnt - b0), 32'd1440);

        // Abort during DATA bit 3, then resume with the next queued byte
        apb_en = 1'b0; apb_brg = 8'd0; apb_bsel = 1'b1;
        step(1);
        apb_en = 1'b1;
        push(8'h3C); push(8'h81);
        step(1);
        step(34);
        apb_en = 1'b0;
        step(1);
        chk("abort_txd",  32'(uart_txd),   32'd1);
        chk("abort_busy", 32'(tx_busy),    32'd0);
        chk("abort_pop",  32'(tx_txff_rd), 32'd0);
        p0 = pop_cnt;
        step(5);
        chk("abort_nopop", 32'(pop_cnt - p0), 32'd0);
        b0 = busy_cnt; p0 = pop_cnt;
        apb_en = 1'b1;
        step(90);
        chk("resume_pops", 32'(pop_cnt - p0), 32'd1);
        chk("resume_busy", 32'(busy_cnt - b0), 32'd80);

        // Reset mid-frame
        push(8'h5A);
        step(20);
        prst_n = 1'b0;
        #1;
        chk("mrst_txd",  32'(uart_txd),   32'd1);
        chk("mrst_busy", 32'(tx_busy),    32'd0);
        chk("mrst_pop",  32'(tx_txff_rd), 32'd0);
        step(3);
        prst_n = 1'b1;
        p0 = pop_cnt;
        step(30);
        chk("mrst_nopop", 32'(pop_cnt - p0), 32'd0);
        b0 = busy_cnt; p0 = pop_cnt;
        push(8'h11);
        step(90);
        chk("mrst_pops", 32'(pop_cnt - p0), 32'd1);
        chk("mrst_busy80", 32'(busy_cnt - b0), 32'd80);

        // Nothing queued: line stays idle, no pops
        p0 = pop_cnt; o0 = one_cnt;
        step(1000);
        chk("idle_pops", 32'(pop_cnt - p0), 32'd0);
        chk("idle_high", 32'(one_cnt - o0), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
